// File: rtl/ballot_unit.sv
// ballot_unit: voter-side front end for the vote-counting machine.
// Synchronises and debounces the candidate keypad, allows one vote per
// officer arming, rejects multi-key presses and drives a timed one-hot
// cand_out / vote_btn window.
// Optional: define BALLOT_TIMEOUT_EN to abandon an armed ballot after
// ARM_TIMEOUT cycles without a vote.
module ballot_unit #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int HOLD_CYC     = 5,
  parameter int LOCKOUT_CYC  = 8,
  parameter int ARM_TIMEOUT  = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       officer_arm,
  input  logic [3:0] key,
  output logic [3:0] cand_out,
  output logic       vote_btn,
  output logic       armed,
  output logic       reject,
  output logic [7:0] ballots_cast,
  output logic       timeout
);

  typedef enum logic [2:0] {IDLE, RELEASE, ARMED, SEND, LOCKOUT} state_t;

  state_t     state, state_nx;
  logic [1:0] arm_sync;
  logic       arm_prev;
  logic [3:0] key_s1, key_s2, key_prev;
  logic [7:0] db_cnt, win_cnt;
  logic [3:0] cand_reg;
  logic       arm_edge, key_stable, one_hot, db_done, send_last;

  assign arm_edge   = arm_sync[1] & ~arm_prev;
  assign key_stable = (key_s2 != 4'd0) && (key_s2 == key_prev);
  assign one_hot    = (key_s2 != 4'd0) && ((key_s2 & (key_s2 - 4'd1)) == 4'd0);
  assign db_done    = (state == ARMED) && key_stable && (db_cnt == 8'(DEBOUNCE_CYC - 1));
  assign send_last  = (state == SEND) && (win_cnt == 8'(HOLD_CYC - 1));

  // Two-flop synchronisers plus one extra sample for edge / stability checks
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      arm_sync <= '0;
      arm_prev <= 1'b0;
      key_s1   <= '0;
      key_s2   <= '0;
      key_prev <= '0;
    end else begin
      arm_sync <= {arm_sync[0], officer_arm};
      arm_prev <= arm_sync[1];
      key_s1   <= key;
      key_s2   <= key_s1;
      key_prev <= key_s2;
    end
  end

`ifdef BALLOT_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        to_hit;
  assign to_hit = ((state == RELEASE) || (state == ARMED)) &&
                  (to_cnt == 16'(ARM_TIMEOUT - 1)) && !db_done;

  // Arm-expiry counter: restarts on every entry to RELEASE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                    to_cnt <= '0;
    else if (state_nx == RELEASE && state != RELEASE) to_cnt <= '0;
    else if (state == RELEASE || state == ARMED)   to_cnt <= to_cnt + 16'd1;
    else                                           to_cnt <= '0;
  end
`endif

  // State register, debounce / window counters, latched vote and tally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      db_cnt       <= '0;
      win_cnt      <= '0;
      cand_reg     <= '0;
      ballots_cast <= '0;
    end else begin
      state  <= state_nx;
      db_cnt <= (state == ARMED && key_stable) ? db_cnt + 8'd1 : 8'd0;
      if (state_nx != state || (state != SEND && state != LOCKOUT)) win_cnt <= '0;
      else                                                         win_cnt <= win_cnt + 8'd1;
      if (db_done && one_hot) cand_reg <= key_s2;
      // Tally lands on the last SEND cycle, so a reset inside the window loses it
      if (send_last && ballots_cast != 8'hFF) ballots_cast <= ballots_cast + 8'd1;
    end
  end

  // Next-state and outputs; outputs decode from the registered state only
  always_comb begin
    state_nx = state;
    cand_out = '0;
    vote_btn = 1'b0;
    armed    = 1'b0;
    reject   = 1'b0;
    timeout  = 1'b0;
    case (state)
      IDLE:    if (arm_edge) state_nx = RELEASE;
      RELEASE: begin
        armed = 1'b1;
        if (key_s2 == 4'd0) state_nx = ARMED;
      end
      ARMED: begin
        armed = 1'b1;
        if (db_done) begin
          if (one_hot) state_nx = SEND;
          else begin
            reject   = 1'b1;
            state_nx = RELEASE;
          end
        end
      end
      SEND: begin
        vote_btn = 1'b1;
        cand_out = cand_reg;
        if (send_last) state_nx = LOCKOUT;
      end
      LOCKOUT: if (win_cnt == 8'(LOCKOUT_CYC - 1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
`ifdef BALLOT_TIMEOUT_EN
    // A debounce completing on the expiry cycle takes priority (to_hit masks it)
    if (to_hit) begin
      timeout  = 1'b1;
      state_nx = IDLE;
    end
`endif
  end

endmodule

// File: tb/tb_ballot_unit.sv
// Directed self-checking bench for ballot_unit (D=4, H=5, L=8, ARM_TIMEOUT=20).
module tb_ballot_unit;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       officer_arm = 1'b0;
  logic [3:0] key = 4'd0;
  logic [3:0] cand_out;
  logic       vote_btn, armed, reject, timeout;
  logic [7:0] ballots_cast;

  int checks = 0;
  int fails  = 0;

  ballot_unit #(.DEBOUNCE_CYC(4), .HOLD_CYC(5), .LOCKOUT_CYC(8), .ARM_TIMEOUT(20)) dut (
    .clk(clk), .reset(reset), .officer_arm(officer_arm), .key(key),
    .cand_out(cand_out), .vote_btn(vote_btn), .armed(armed), .reject(reject),
    .ballots_cast(ballots_cast), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Watchdog so the bench always ends
  initial begin
    #1000000;
    $display("FAIL watchdog: observed=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Rising officer_arm reaches RELEASE 3 edges later; leaves unit in ARMED
  task automatic do_arm();
    officer_arm = 1'b1;
    repeat (3) step();
    check("arm_lamp", {7'd0, armed}, 8'd1);
    officer_arm = 1'b0;
    repeat (2) step();
  endtask

  // Press from ARMED; first vote_btn cycle is DEBOUNCE_CYC+3 = 7 edges later
  task automatic press_and_vote(input logic [3:0] k, input logic [7:0] exp_cnt);
    int hi;
    key = k;
    repeat (6) step();
    check("btn_early", {7'd0, vote_btn}, 8'd0);
    step();
    check("btn_first", {7'd0, vote_btn}, 8'd1);
    check("cand", {4'd0, cand_out}, {4'd0, k});
    check("armed_in_send", {7'd0, armed}, 8'd0);
    hi = 1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) key = 4'd0;
      step();
      if (vote_btn === 1'b1 && cand_out === k) hi++;
    end
    check("btn_window", 8'(hi), 8'd5);
    step();
    check("btn_off", {7'd0, vote_btn}, 8'd0);
    check("cand_off", {4'd0, cand_out}, 8'd0);
    check("count", ballots_cast, exp_cnt);
  endtask

  initial begin
    int n;
    // 1: reset state, keys in IDLE ignored
    repeat (2) step();
    check("rst_cand", {4'd0, cand_out}, 8'd0);
    check("rst_btn", {7'd0, vote_btn}, 8'd0);
    check("rst_armed", {7'd0, armed}, 8'd0);
    check("rst_reject", {7'd0, reject}, 8'd0);
    check("rst_timeout", {7'd0, timeout}, 8'd0);
    check("rst_count", ballots_cast, 8'd0);
    reset = 1'b1;
    step();
    key = 4'b0100;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (vote_btn !== 1'b0 || armed !== 1'b0) n++;
    end
    check("idle_keys_ignored", 8'(n), 8'd0);
    key = 4'd0;
    repeat (3) step();

    // 2: clean vote, then exact lockout length (arm edge in first IDLE cycle)
    do_arm();
    press_and_vote(4'b0100, 8'd1);
    repeat (6) step();
    officer_arm = 1'b1;
    repeat (3) step();
    check("lockout_len", {7'd0, armed}, 8'd1);
    officer_arm = 1'b0;
    repeat (2) step();

    // 3: multi-hot press rejected, retry with a single key
    key = 4'b0011;
    repeat (5) step();
    check("reject_early", {7'd0, reject}, 8'd0);
    step();
    check("reject_pulse", {7'd0, reject}, 8'd1);
    step();
    check("reject_once", {7'd0, reject}, 8'd0);
    check("reject_release", {7'd0, armed}, 8'd1);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (vote_btn !== 1'b0 || reject !== 1'b0) n++;
    end
    check("held_after_reject", 8'(n), 8'd0);
    key = 4'd0;
    repeat (4) step();
    press_and_vote(4'b0010, 8'd2);
    // arm edge in the last LOCKOUT cycle is dropped; held level never re-arms
    repeat (5) step();
    officer_arm = 1'b1;
    repeat (3) step();
    check("lockout_ignores_arm", {7'd0, armed}, 8'd0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (armed !== 1'b0) n++;
    end
    check("held_arm_no_rearm", 8'(n), 8'd0);
    officer_arm = 1'b0;
    repeat (4) step();

    // 4: bouncing key, then settle
    do_arm();
    n = 0;
    for (int i = 0; i < 2; i++) begin
      key = 4'b0001;
      repeat (2) step();
      if (vote_btn !== 1'b0) n++;
      key = 4'b0000;
      repeat (2) step();
      if (vote_btn !== 1'b0) n++;
    end
    check("bounce_no_vote", 8'(n), 8'd0);
    press_and_vote(4'b0001, 8'd3);
    repeat (8) step();

    // 5a: officer_arm held high across three presses -> one vote
    officer_arm = 1'b1;
    repeat (4) step();
    press_and_vote(4'b0001, 8'd4);
    repeat (8) step();
    n = 0;
    for (int p = 0; p < 2; p++) begin
      key = 4'b1000;
      for (int i = 0; i < 15; i++) begin
        step();
        if (vote_btn !== 1'b0) n++;
      end
      key = 4'd0;
      repeat (3) step();
    end
    check("held_arm_one_vote", 8'(n), 8'd0);
    check("held_arm_count", ballots_cast, 8'd4);
    officer_arm = 1'b0;
    repeat (4) step();

    // 5b: saturation at 255
    for (int v = 5; v <= 256; v++) begin
      do_arm();
      press_and_vote(4'b0001 << (v % 4), (v > 255) ? 8'd255 : 8'(v));
      repeat (8) step();
    end
    check("saturated", ballots_cast, 8'd255);

    // 5c: async reset inside the SEND window
    do_arm();
    key = 4'b0100;
    repeat (7) step();
    check("mid_send_btn", {7'd0, vote_btn}, 8'd1);
    step();
    check("mid_send_count", ballots_cast, 8'd255);
    reset = 1'b0;
    #1;
    check("rst_btn_async", {7'd0, vote_btn}, 8'd0);
    check("rst_cand_async", {4'd0, cand_out}, 8'd0);
    check("rst_count_clear", ballots_cast, 8'd0);
    key = 4'd0;
    step();
    reset = 1'b1;
    repeat (3) step();

`ifdef BALLOT_TIMEOUT_EN
    // 6: arm expiry after 20 cycles in RELEASE/ARMED
    officer_arm = 1'b1;
    for (int i = 1; i <= 23; i++) begin
      step();
      if (i == 4) officer_arm = 1'b0;
      if (i == 21) check("to_early", {7'd0, timeout}, 8'd0);
      if (i == 21) check("to_still_armed", {7'd0, armed}, 8'd1);
      if (i == 22) check("to_pulse", {7'd0, timeout}, 8'd1);
      if (i == 23) check("to_once", {7'd0, timeout}, 8'd0);
      if (i == 23) check("to_idle", {7'd0, armed}, 8'd0);
    end
    check("to_count", ballots_cast, 8'd0);
`else
    // 6: without the timeout feature ARMED waits indefinitely
    do_arm();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (timeout !== 1'b0 || armed !== 1'b1) n++;
    end
    check("no_timeout", 8'(n), 8'd0);
    press_and_vote(4'b1000, 8'd1);
    repeat (8) step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
